// File: rtl/spi_prog_loader.sv
// Image-buffer to serial loader for tt_um_tiny_processor: streams instruction then register words
// MSB-first with a per-word done_in handshake, or reads them back and records the first mismatch.
module spi_prog_loader #(
  parameter int nInstructions = 16,
  parameter int nRegisters    = 16,
  parameter int DATA_W        = 8,
  parameter int CLK_DIV       = 2,
  parameter int TIMEOUT       = 64,
  parameter int AW = ($clog2((nInstructions > nRegisters) ? nInstructions : nRegisters) < 1) ? 1 :
                      $clog2((nInstructions > nRegisters) ? nInstructions : nRegisters)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              img_we,
  input  logic              img_seg,
  input  logic [AW-1:0]     img_addr,
  input  logic [DATA_W-1:0] img_wdata,
  input  logic              start,
  input  logic              verify,
  output logic [1:0]        mode_out,
  output logic              rd_out,
  output logic              sclk,
  output logic              mosi_out,
  input  logic              miso,
  input  logic              done_in,
  output logic              busy,
  output logic              done_out,
  output logic              err_out,
  output logic              err_seg,
  output logic [AW-1:0]     err_addr
);

  localparam int PW = $clog2(2 * CLK_DIV);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_ACK, S_DONE} state_e;

  state_e            state_q, state_d;
  logic              seg_q, seg_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              verify_q, verify_d;
  logic [DATA_W-1:0] cap_q, cap_d;
  logic              err_q, err_d;
  logic              err_seg_q, err_seg_d;
  logic [AW-1:0]     err_addr_q, err_addr_d;
  logic [DATA_W-1:0] instr_q [nInstructions];
  logic [DATA_W-1:0] instr_d [nInstructions];
  logic [DATA_W-1:0] regs_q  [nRegisters];
  logic [DATA_W-1:0] regs_d  [nRegisters];
  logic [DATA_W-1:0] cur_word;

  assign busy     = (state_q == S_SHIFT) || (state_q == S_ACK);
  assign cur_word = seg_q ? regs_q[addr_q] : instr_q[addr_q];
  assign sclk     = (state_q == S_SHIFT) && (phase_q >= PW'(CLK_DIV));
  assign mosi_out = (state_q == S_SHIFT) && !verify_q && cur_word[BW'(DATA_W - 1) - bit_q];
  assign mode_out = busy ? (seg_q ? 2'b10 : 2'b01) : 2'b00;
  assign rd_out   = busy && verify_q;
  assign done_out = (state_q == S_DONE);
  assign err_out  = err_q;
  assign err_seg  = err_seg_q;
  assign err_addr = err_addr_q;

  // Host writes land only between runs so the image cannot change under a transfer.
  always_comb begin
    instr_d = instr_q;
    regs_d  = regs_q;
    if (img_we && !busy) begin
      if (!img_seg && int'(img_addr) < nInstructions) instr_d[img_addr] = img_wdata;
      if (img_seg && int'(img_addr) < nRegisters)     regs_d[img_addr]  = img_wdata;
    end
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first, otherwise unassigned paths infer latches.
    state_d    = state_q;
    seg_d      = seg_q;
    addr_d     = addr_q;
    bit_d      = bit_q;
    phase_d    = phase_q;
    tmo_d      = tmo_q;
    verify_d   = verify_q;
    cap_d      = cap_q;
    err_d      = err_q;
    err_seg_d  = err_seg_q;
    err_addr_d = err_addr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_SHIFT;
          verify_d   = verify;
          err_d      = 1'b0;
          err_seg_d  = 1'b0;
          err_addr_d = '0;
          seg_d      = 1'b0;
          addr_d     = '0;
          bit_d      = '0;
          phase_d    = '0;
        end
      end
      S_SHIFT: begin
        if (phase_q == PW'(2 * CLK_DIV - 1)) begin
          cap_d   = DATA_W'({cap_q, miso});
          phase_d = '0;
          if (bit_q == BW'(DATA_W - 1)) begin
            state_d = S_ACK;
            bit_d   = '0;
            tmo_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_ACK: begin
        // tmo_q is zero only on the entry cycle, when cap_q holds the complete word.
        if (verify_q && tmo_q == '0 && cap_q != cur_word && !err_q) begin
          err_d      = 1'b1;
          err_seg_d  = seg_q;
          err_addr_d = addr_q;
        end
        if (done_in) begin
          if (seg_q && addr_q == AW'(nRegisters - 1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SHIFT;
            if (!seg_q && addr_q == AW'(nInstructions - 1)) begin
              seg_d  = 1'b1;
              addr_d = '0;
            end else begin
              addr_d = addr_q + 1'b1;
            end
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d = S_DONE;
          if (!err_q) begin
            err_d      = 1'b1;
            err_seg_d  = seg_q;
            err_addr_d = addr_q;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      seg_q      <= 1'b0;
      addr_q     <= '0;
      bit_q      <= '0;
      phase_q    <= '0;
      tmo_q      <= '0;
      verify_q   <= 1'b0;
      cap_q      <= '0;
      err_q      <= 1'b0;
      err_seg_q  <= 1'b0;
      err_addr_q <= '0;
      // NOTE: the image flops are reset as well, since a run after reset must stream zeros.
      instr_q    <= '{default: '0};
      regs_q     <= '{default: '0};
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q    <= state_d;
      seg_q      <= seg_d;
      addr_q     <= addr_d;
      bit_q      <= bit_d;
      phase_q    <= phase_d;
      tmo_q      <= tmo_d;
      verify_q   <= verify_d;
      cap_q      <= cap_d;
      err_q      <= err_d;
      err_seg_q  <= err_seg_d;
      err_addr_q <= err_addr_d;
      instr_q    <= instr_d;
      regs_q     <= regs_d;
    end
  end

endmodule

// File: tb/tb_spi_prog_loader.sv
// Self-checking bench for spi_prog_loader: a serial target model answers miso/done_in and
// records the bit stream, which is compared against an image model kept in the bench.
module tb_spi_prog_loader;

  localparam int NI       = 16;
  localparam int NR       = 16;
  localparam int NW       = NI + NR;
  localparam int DW       = 8;
  localparam int CD       = 2;
  localparam int TO       = 64;
  localparam int AW       = 4;
  localparam int WORD_CYC = DW * 2 * CD;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          img_we = 1'b0;
  logic          img_seg = 1'b0;
  logic [AW-1:0] img_addr = '0;
  logic [DW-1:0] img_wdata = '0;
  logic          start = 1'b0;
  logic          verify = 1'b0;
  logic          miso = 1'b0;
  logic          done_in = 1'b0;
  logic [1:0]    mode_out;
  logic          rd_out, sclk, mosi_out, busy, done_out, err_out, err_seg;
  logic [AW-1:0] err_addr;

  spi_prog_loader #(
    .nInstructions(NI), .nRegisters(NR), .DATA_W(DW), .CLK_DIV(CD), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .img_we(img_we), .img_seg(img_seg), .img_addr(img_addr),
    .img_wdata(img_wdata), .start(start), .verify(verify), .mode_out(mode_out),
    .rd_out(rd_out), .sclk(sclk), .mosi_out(mosi_out), .miso(miso), .done_in(done_in),
    .busy(busy), .done_out(done_out), .err_out(err_out), .err_seg(err_seg), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference image
  logic [DW-1:0] instr_m [NI];
  logic [DW-1:0] reg_m   [NR];

  // Target model state
  logic          mosi_hist [$];
  logic [1:0]    mode_hist [$];
  logic [DW-1:0] resp_word [NW];
  bit            resp_en = 1'b0;
  bit            exp_rd = 1'b0;
  int            resp_base = 0;
  int            hang_abs = -1;
  int            ack_delay = 0;
  int            word_cnt = 0;
  int            bit_in_word = 0;
  int            ack_cd = 0;
  int            busy_cnt = 0;
  int            done_cnt = 0;
  int            rd_bad = 0;
  int            rd_hi = 0;
  int            rel;
  logic          sclk_prev = 1'b0;

  // Run results
  bit            r_done;
  logic          r_err, r_seg;
  logic [AW-1:0] r_addr;
  int            r_busy, r_words, r_done_cnt, r_rdbad, r_rdhi, b_bits;

  always @(negedge clk) begin
    done_in = 1'b0;
    if (!rst_n) begin
      bit_in_word = 0;
      ack_cd      = 0;
      sclk_prev   = 1'b0;
      miso        = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (busy && rd_out) rd_hi++;
      if (rd_out !== (busy && exp_rd)) rd_bad++;
      if (done_out) done_cnt++;
      if (sclk && !sclk_prev) begin
        mosi_hist.push_back(mosi_out);
        mode_hist.push_back(mode_out);
        rel  = word_cnt - resp_base;
        miso = (resp_en && rel >= 0 && rel < NW) ? resp_word[rel][DW-1-bit_in_word] : 1'b0;
        bit_in_word++;
        if (bit_in_word == DW) begin
          bit_in_word = 0;
          if (word_cnt != hang_abs) ack_cd = CD + ack_delay + 1;
          word_cnt++;
        end
      end else if (ack_cd > 0) begin
        ack_cd--;
        if (ack_cd == 1) begin
          done_in = 1'b1;
          ack_cd  = 0;
        end
      end
      sclk_prev = sclk;
    end
  end

  function automatic int count_stream_errs(input int bbase, input bit zero);
    int k;
    int n;
    logic [DW-1:0] word;
    logic [1:0] m;
    k = 0;
    n = 0;
    for (int w = 0; w < NW; w++) begin
      word = (w < NI) ? instr_m[w] : reg_m[w-NI];
      m    = (w < NI) ? 2'b01 : 2'b10;
      for (int b = DW - 1; b >= 0; b--) begin
        if (bbase + k >= mosi_hist.size()) n++;
        else if (mosi_hist[bbase+k] !== (zero ? 1'b0 : word[b]) || mode_hist[bbase+k] !== m) n++;
        k++;
      end
    end
    if (mosi_hist.size() - bbase != k) n++;
    return n;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NI; i++) instr_m[i] = '0;
    for (int i = 0; i < NR; i++) reg_m[i] = '0;
  endtask

  task automatic write_img(input bit s, input int a, input logic [DW-1:0] d);
    @(negedge clk);
    img_we = 1'b1; img_seg = s; img_addr = AW'(a); img_wdata = d;
    @(negedge clk);
    img_we = 1'b0;
    if (s) reg_m[a] = d;
    else   instr_m[a] = d;
  endtask

  task automatic load_image(input bit rnd);
    for (int i = 0; i < NI; i++) write_img(1'b0, i, rnd ? DW'($urandom) : DW'(8'h11 * i));
    for (int j = 0; j < NR; j++) write_img(1'b1, j, rnd ? DW'($urandom) : DW'(8'hF0 ^ j));
  endtask

  task automatic run_once(input bit v, input int delay, input int hang_rel, input bit poke);
    int n;
    int b_words, b_busy, b_done, b_rdbad, b_rdhi;
    b_bits    = mosi_hist.size();
    b_words   = word_cnt;
    b_busy    = busy_cnt;
    b_done    = done_cnt;
    b_rdbad   = rd_bad;
    b_rdhi    = rd_hi;
    resp_base = word_cnt;
    hang_abs  = (hang_rel >= 0) ? word_cnt + hang_rel : -1;
    ack_delay = delay;
    exp_rd    = v;
    @(negedge clk); start = 1'b1; verify = v;
    @(negedge clk); start = 1'b0; verify = 1'b0;
    r_done = 1'b0;
    n = 0;
    while (!r_done && n < 5000) begin
      if (poke && n == 40) begin
        start = 1'b1; img_we = 1'b1; img_seg = 1'b0; img_addr = '0; img_wdata = ~instr_m[0];
      end
      if (poke && n == 41) begin start = 1'b0; img_we = 1'b0; end
      if (done_out) begin
        r_done = 1'b1; r_err = err_out; r_seg = err_seg; r_addr = err_addr;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    start = 1'b0; img_we = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    r_words    = word_cnt - b_words;
    r_busy     = busy_cnt - b_busy;
    r_done_cnt = done_cnt - b_done;
    r_rdbad    = rd_bad - b_rdbad;
    r_rdhi     = rd_hi - b_rdhi;
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if ({sclk, mosi_out, mode_out, rd_out, busy, done_out, err_out, err_seg, err_addr} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0",
               {sclk, mosi_out, mode_out, rd_out, busy, done_out, err_out, err_seg, err_addr});
    end
    #1 rst_n = 1'b1;
    clear_model();
    resp_en = 1'b0;
    run_once(1'b0, 0, -1, 1'b0);
    checks++;
    if (r_done !== 1'b1) begin errors++; $display("FAIL zero_done: got %0d required 1", r_done); end
    n = count_stream_errs(b_bits, 1'b1);
    checks++;
    if (n !== 0) begin errors++; $display("FAIL zero_stream: bit errors %0d required 0", n); end
    checks++;
    if (r_err !== 1'b0) begin errors++; $display("FAIL zero_err: got %0d required 0", r_err); end
    checks++;
    if (r_words !== NW) begin errors++; $display("FAIL zero_words: got %0d required %0d", r_words, NW); end
  endtask

  task automatic test_program();
    int n;
    load_image(1'b0);
    resp_en = 1'b0;
    run_once(1'b0, 3, -1, 1'b0);
    checks++;
    if (r_done !== 1'b1) begin errors++; $display("FAIL prog_done: got %0d required 1", r_done); end
    checks++;
    if (r_done_cnt !== 1) begin errors++; $display("FAIL prog_done_pulses: got %0d required 1", r_done_cnt); end
    n = count_stream_errs(b_bits, 1'b0);
    checks++;
    if (n !== 0) begin errors++; $display("FAIL prog_stream: bit errors %0d required 0", n); end
    checks++;
    if (r_err !== 1'b0) begin errors++; $display("FAIL prog_err: got %0d required 0", r_err); end
    checks++;
    if (r_busy !== NW * (WORD_CYC + 4)) begin
      errors++; $display("FAIL prog_busy_cycles: got %0d required %0d", r_busy, NW * (WORD_CYC + 4));
    end
    checks++;
    if (r_rdbad !== 0) begin errors++; $display("FAIL prog_rd_out: bad cycles %0d required 0", r_rdbad); end
  endtask

  task automatic test_verify_match();
    int n;
    for (int w = 0; w < NW; w++) resp_word[w] = (w < NI) ? instr_m[w] : reg_m[w-NI];
    resp_en = 1'b1;
    run_once(1'b1, 0, -1, 1'b0);
    checks++;
    if (r_done !== 1'b1) begin errors++; $display("FAIL vmatch_done: got %0d required 1", r_done); end
    n = count_stream_errs(b_bits, 1'b1);
    checks++;
    if (n !== 0) begin errors++; $display("FAIL vmatch_mosi_low: bit errors %0d required 0", n); end
    checks++;
    if (r_rdbad !== 0) begin errors++; $display("FAIL vmatch_rd_out: bad cycles %0d required 0", r_rdbad); end
    checks++;
    if (r_rdhi !== NW * (WORD_CYC + 1)) begin
      errors++; $display("FAIL vmatch_rd_high: got %0d required %0d", r_rdhi, NW * (WORD_CYC + 1));
    end
    checks++;
    if (r_err !== 1'b0) begin errors++; $display("FAIL vmatch_err: got %0d required 0", r_err); end
  endtask

  task automatic test_verify_mismatch();
    int first;
    logic [DW-1:0] img;
    for (int w = 0; w < NW; w++) resp_word[w] = (w < NI) ? instr_m[w] : reg_m[w-NI];
    resp_word[NI+5] = reg_m[5] ^ 8'h01;
    resp_word[NI+9] = reg_m[9] ^ DW'($urandom_range(1, 255));
    first = -1;
    for (int w = 0; w < NW; w++) begin
      img = (w < NI) ? instr_m[w] : reg_m[w-NI];
      if (first < 0 && resp_word[w] != img) first = w;
    end
    resp_en = 1'b1;
    run_once(1'b1, 0, -1, 1'b0);
    resp_en = 1'b0;
    checks++;
    if (r_err !== 1'b1) begin errors++; $display("FAIL vmis_err: got %0d required 1", r_err); end
    checks++;
    if (r_seg !== (first >= NI)) begin errors++; $display("FAIL vmis_seg: got %0d required %0d", r_seg, first >= NI); end
    checks++;
    if (r_addr !== AW'((first >= NI) ? first - NI : first)) begin
      errors++; $display("FAIL vmis_addr: got %0d required %0d", r_addr, (first >= NI) ? first - NI : first);
    end
    checks++;
    if (r_words !== NW) begin errors++; $display("FAIL vmis_words: got %0d required %0d", r_words, NW); end
    checks++;
    if (r_done_cnt !== 1) begin errors++; $display("FAIL vmis_done: got %0d required 1", r_done_cnt); end
  endtask

  task automatic test_ideal_random();
    int n;
    load_image(1'b1);
    resp_en = 1'b0;
    run_once(1'b0, 0, -1, 1'b0);
    n = count_stream_errs(b_bits, 1'b0);
    checks++;
    if (n !== 0) begin errors++; $display("FAIL ideal_stream: bit errors %0d required 0", n); end
    checks++;
    if (r_busy !== NW * (WORD_CYC + 1)) begin
      errors++; $display("FAIL ideal_busy_cycles: got %0d required %0d", r_busy, NW * (WORD_CYC + 1));
    end
    checks++;
    if ({r_err, r_seg, r_addr} !== '0) begin
      errors++; $display("FAIL ideal_err_cleared: got %h required 0", {r_err, r_seg, r_addr});
    end
  endtask

  task automatic test_timeout();
    int n;
    resp_en = 1'b0;
    run_once(1'b0, 0, 3, 1'b1);
    checks++;
    if (r_done !== 1'b1) begin errors++; $display("FAIL tmo_done: got %0d required 1", r_done); end
    checks++;
    if (r_err !== 1'b1) begin errors++; $display("FAIL tmo_err: got %0d required 1", r_err); end
    checks++;
    if (r_seg !== 1'b0) begin errors++; $display("FAIL tmo_seg: got %0d required 0", r_seg); end
    checks++;
    if (r_addr !== AW'(3)) begin errors++; $display("FAIL tmo_addr: got %0d required 3", r_addr); end
    checks++;
    if (r_busy !== 3 * (WORD_CYC + 1) + WORD_CYC + TO) begin
      errors++; $display("FAIL tmo_busy_cycles: got %0d required %0d", r_busy, 3 * (WORD_CYC + 1) + WORD_CYC + TO);
    end
    checks++;
    if (r_done_cnt !== 1) begin errors++; $display("FAIL tmo_done_pulses: got %0d required 1", r_done_cnt); end
    // The write issued while busy must not have reached the image.
    run_once(1'b0, 0, -1, 1'b0);
    n = count_stream_errs(b_bits, 1'b0);
    checks++;
    if (n !== 0) begin errors++; $display("FAIL busy_write_ignored: bit errors %0d required 0", n); end
  endtask

  task automatic test_reset_mid();
    int base;
    int n;
    bit hit;
    load_image(1'b1);
    resp_en   = 1'b0;
    hang_abs  = -1;
    ack_delay = 0;
    exp_rd    = 1'b0;
    base      = word_cnt;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    hit = 1'b0;
    n = 0;
    while (!hit && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
      if (word_cnt - base == 7 && bit_in_word == 3) hit = 1'b1;
    end
    checks++;
    if (hit !== 1'b1) begin errors++; $display("FAIL mid_reach_word7: got %0d required 1", hit); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sclk, mosi_out, mode_out, rd_out, busy, done_out, err_out, err_seg, err_addr} !== 13'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %h required 0",
               {sclk, mosi_out, mode_out, rd_out, busy, done_out, err_out, err_seg, err_addr});
    end
    clear_model();
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    load_image(1'b1);
    run_once(1'b0, 0, -1, 1'b0);
    n = count_stream_errs(b_bits, 1'b0);
    checks++;
    if (n !== 0) begin errors++; $display("FAIL mid_restart_stream: bit errors %0d required 0", n); end
    checks++;
    if (r_done !== 1'b1) begin errors++; $display("FAIL mid_restart_done: got %0d required 1", r_done); end
  endtask

  initial begin
    test_reset();
    test_program();
    test_verify_match();
    test_verify_mismatch();
    test_ideal_random();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_prog_loader.md
# spi_prog_loader

Parametrised program/register loader that sits between a host-side image buffer and the `tt_um_tiny_processor` serial load port. It replaces the fixed 16×16 testbench driver with synthesizable logic that has a configurable word width, depth and SPI clock divider. It streams the instruction segment and then the register segment MSB-first, handshaking each word on `done_in`. A readback/verify mode compares `miso` against the stored image and records the first mismatch.

## Interface
- `nInstructions`, default 16: instruction words in the image; must be ≥1.
- `nRegisters`, default 16: register words in the image; must be ≥1.
- `DATA_W`, default 8: bits per word.
- `CLK_DIV`, default 2: `clk` cycles per `sclk` half-period; must be ≥1.
- `TIMEOUT`, default 64: maximum wait cycles for `done_in` per word.
- `AW`, derived: `$clog2(max(nInstructions,nRegisters))`, minimum 1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `img_we`  in  1  image write strobe.
- `img_seg`  in  1  image segment select: 0 = instruction, 1 = register.
- `img_addr`  in  AW  image word address.
- `img_wdata`  in  DATA_W  image write data.
- `start`  in  1  one-cycle start pulse.
- `verify`  in  1  sampled with `start`: 0 = program, 1 = readback-compare.
- `mode_out`  out  2  segment indicator: 00 idle, 01 instruction, 10 register.
- `rd_out`  out  1  high throughout a verify run.
- `sclk`  out  1  serial clock, idle low.
- `mosi_out`  out  1  serial data.
- `miso`  in  1  target readback data.
- `done_in`  in  1  target word acknowledge.
- `busy`  out  1  run in progress.
- `done_out`  out  1  one-cycle pulse at the end of a run.
- `err_out`  out  1  sticky error flag.
- `err_seg`  out  1  segment of the first error.
- `err_addr`  out  AW  address of the first error.

## Operation
- The image is held in flops: nInstructions + nRegisters words. It is written only when `busy` = 0. Writes with `busy` = 1 or with an out-of-range address are dropped.
- FSM states: IDLE, SHIFT, ACK, DONE.
- IDLE → SHIFT on `start`.
  - Latch `verify`.
  - Clear `err_out`, `err_seg` and `err_addr`.
  - Set segment = instruction and address = 0.
- SHIFT: send DATA_W bits MSB first.
  - Program mode: `mosi_out` = current bit.
  - Verify mode: `mosi_out` = 0; shift `miso` into a capture register.
- SHIFT → ACK after the last bit's high half.
- ACK: wait for `done_in` = 1.
  - In verify mode, compare the capture register with the image word on the ACK entry cycle. On a mismatch with `err_out` = 0, set `err_out` = 1 and record `err_seg` and `err_addr`. Later mismatches do not overwrite the record. The run continues.
  - When `done_in` is seen: if this was the last register word, go to DONE. Otherwise advance the address, wrapping from nInstructions−1 to register address 0 with the segment switched, and return to SHIFT.
  - If `TIMEOUT` cycles pass without `done_in`: set `err_out` (if not already set), record the current segment and address, and go to DONE (abort).
- DONE: assert `done_out` for one cycle, then go to IDLE.
- `mode_out` = 01 or 10 from SHIFT entry to DONE according to the current segment; 00 in IDLE and DONE.
- `rd_out` = latched `verify` while `busy`.
- `busy` = 1 in SHIFT and ACK.
- `start` while `busy` is ignored.
- `done_in` seen during SHIFT is ignored.

## Timing
- Reset values: `sclk` 0, `mosi_out` 0, `mode_out` 00, `rd_out` 0, `busy` 0, `done_out` 0, `err_out` 0, `err_seg` 0, `err_addr` 0. FSM resets to IDLE. Image contents reset to 0.
- `rst_n` asserted mid-run forces all outputs to their reset values immediately (asynchronous).
- The first SHIFT cycle follows the cycle in which `start` is sampled. `busy` rises in that same cycle.
- Each bit takes 2·CLK_DIV cycles:
  - `sclk` low for CLK_DIV cycles, with `mosi_out` updated on the first of them;
  - then `sclk` high for CLK_DIV cycles.
  - `miso` is sampled on the last high cycle.
- A word lasts DATA_W·2·CLK_DIV cycles in SHIFT. ACK lasts ≥1 cycle; `done_in` is sampled registered-free in ACK.
- An ideal run (`done_in` tied high) takes (nInstructions+nRegisters)·(DATA_W·2·CLK_DIV+1) cycles of `busy`, then one `done_out` cycle.
- The timeout counter restarts on each ACK entry. The abort is taken on the TIMEOUT-th waiting cycle.

## Test plan
- Reset: hold `rst_n` = 0 for 10 cycles → all outputs at reset values. Pulse `start` with the image all-zero → run completes, `mosi_out` stays 0.
- Program run (defaults, `done_in` high 3 cycles after each word):
  - Image: instr[i] = 8'h11·i, reg[j] = 8'hF0^j.
  - Required: captured `mosi_out` sequence equals the image, MSB first.
  - Required: `mode_out` is 01 for 16 words, then 10 for 16 words.
  - Required: `done_out` pulses once; `err_out` = 0.
- Verify match: drive `miso` with the image bits → `rd_out` = 1 during the run and `err_out` = 0 at `done_out`.
- Verify mismatches at reg[5] (0xF5 driven as 0xF4) and at reg[9] → `err_out` = 1, `err_seg` = 1, `err_addr` = 5. The run continues to all 32 words.
- Timeout at instruction word 3: `done_in` never asserts → 64 cycles later `err_out` = 1, `err_seg` = 0, `err_addr` = 3, then `done_out`. Run with `start` pulsed while busy and `img_we` pulsed while busy → both ignored; image unchanged.
- Reset mid-shift of word 7 → outputs return to reset values the same cycle. A fresh `start` afterwards restarts at instruction address 0.
